// File: rtl/vec_decode_stage_if.sv
// Decode-stage handshake and control bus: instruction fields in, datapath beats out.
interface vec_decode_stage_if #(
  parameter int NUM_LANES     = 16,
  parameter int LANES_PER_UOP = 4
);
  localparam int NUM_UOPS = NUM_LANES / LANES_PER_UOP;
  localparam int IDX_W    = (NUM_UOPS  > 1) ? $clog2(NUM_UOPS)  : 1;
  localparam int BASE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        opcode;
  logic              rd_type;
  logic              rs1_type;
  logic              rs2_type;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        alu_ctrl;
  logic [1:0]        mem_to_reg;
  logic              reg_write;
  logic              vreg_write;
  logic              mem_write;
  logic              branch;
  logic              alu_src;
  logic              is_vec;
  logic [IDX_W-1:0]  uop_idx;
  logic [BASE_W-1:0] lane_base;
  logic              uop_last;
  logic              illegal;

  // Upstream/downstream side: drives instructions and out_ready, observes beats.
  modport master (
    output flush, in_valid, opcode, rd_type, rs1_type, rs2_type, out_ready,
    input  in_ready, out_valid, alu_ctrl, mem_to_reg, reg_write, vreg_write,
           mem_write, branch, alu_src, is_vec, uop_idx, lane_base, uop_last, illegal
  );

  // Decode stage side.
  modport slave (
    input  flush, in_valid, opcode, rd_type, rs1_type, rs2_type, out_ready,
    output in_ready, out_valid, alu_ctrl, mem_to_reg, reg_write, vreg_write,
           mem_write, branch, alu_src, is_vec, uop_idx, lane_base, uop_last, illegal
  );
endinterface

// File: rtl/vec_decode_stage.sv
// Registered decode stage: opcode -> datapath controls, vector ops cracked
// into NUM_LANES/LANES_PER_UOP micro-op beats. Illegal opcodes issue a
// flagged scalar beat with every write/branch control cleared.
module vec_decode_stage #(
  parameter int NUM_LANES     = 16,
  parameter int LANES_PER_UOP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  vec_decode_stage_if.slave bus
);
  localparam int NUM_UOPS = NUM_LANES / LANES_PER_UOP;
  localparam int IDX_W    = (NUM_UOPS  > 1) ? $clog2(NUM_UOPS)  : 1;
  localparam int BASE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, CRACK} state_t;

  typedef struct packed {
    logic [1:0] alu_ctrl;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       vreg_write;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       is_vec;
    logic       illegal;
  } ctrl_t;

  state_t            state_q, state_d;
  ctrl_t             ctrl_q, ctrl_d, dec;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic              last_q, last_d;
  logic              out_valid, accept;

  // Source operand types do not steer any control in this table.
  logic unused_types;
  assign unused_types = bus.rs1_type ^ bus.rs2_type;

  assign out_valid    = (state_q != IDLE);
  // A new instruction may enter only once the final beat is leaving; flush blocks it.
  assign bus.in_ready = !bus.flush && (!out_valid || (bus.out_ready && last_q));
  assign accept       = bus.in_valid && bus.in_ready;

  // Opcode table; rd_type selects the scalar/vector flavour of 11111 and 11110.
  always_comb begin
    dec = '0;
    case (bus.opcode)
      5'b11000: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; end
      5'b10101: dec.reg_write = 1'b1;
      5'b01100: begin dec.alu_ctrl = 2'b11; dec.reg_write = 1'b1; end
      5'b11011: begin dec.mem_to_reg = 2'b01; dec.reg_write = 1'b1; end
      5'b11010: begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; end
      5'b10100: dec.branch = 1'b1;
      5'b11001: dec.branch = 1'b1;
      5'b11111: begin
        dec.alu_ctrl = 2'b10;
        if (bus.rd_type) begin dec.vreg_write = 1'b1; dec.is_vec = 1'b1; end
        else             dec.reg_write = 1'b1;
      end
      5'b11110: begin
        if (bus.rd_type) begin
          dec.mem_to_reg = 2'b10; dec.alu_src = 1'b1;
          dec.vreg_write = 1'b1;  dec.is_vec  = 1'b1;
        end else begin
          dec.alu_ctrl = 2'b01; dec.reg_write = 1'b1;
        end
      end
      5'b10001: begin dec.vreg_write = 1'b1; dec.is_vec = 1'b1; end
      5'b10010: begin dec.alu_src = 1'b1; dec.vreg_write = 1'b1; dec.is_vec = 1'b1; end
      5'b00001: begin dec.mem_to_reg = 2'b10; dec.vreg_write = 1'b1; dec.is_vec = 1'b1; end
      5'b11100: begin dec.alu_ctrl = 2'b11; dec.vreg_write = 1'b1; dec.is_vec = 1'b1; end
      5'b10110: begin dec.mem_to_reg = 2'b01; dec.vreg_write = 1'b1; dec.is_vec = 1'b1; end
      5'b10111: begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; dec.is_vec = 1'b1; end
      default:  dec.illegal = 1'b1;
    endcase
  end

  // Next state: flush beats accept, accept beats micro-op advance.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    idx_d   = idx_q;
    base_d  = base_q;
    last_d  = last_q;
    if (bus.flush) begin
      state_d = IDLE;
      ctrl_d  = '0;
      idx_d   = '0;
      base_d  = '0;
      last_d  = 1'b0;
    end else if (accept) begin
      ctrl_d = dec;
      idx_d  = '0;
      base_d = '0;
      if (dec.is_vec && (NUM_UOPS > 1)) begin
        state_d = CRACK;
        last_d  = 1'b0;
      end else begin
        state_d = HOLD;
        last_d  = 1'b1;
      end
    end else if (bus.out_ready) begin
      case (state_q)
        CRACK: begin
          idx_d  = idx_q + 1'b1;
          base_d = base_q + BASE_W'(LANES_PER_UOP);
          if (idx_d == IDX_W'(NUM_UOPS - 1)) begin
            state_d = HOLD;
            last_d  = 1'b1;
          end
        end
        HOLD: begin
          state_d = IDLE;
          ctrl_d  = '0;
          idx_d   = '0;
          base_d  = '0;
          last_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Stage register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      last_q  <= last_d;
    end
  end

  assign bus.out_valid  = out_valid;
  assign bus.alu_ctrl   = ctrl_q.alu_ctrl;
  assign bus.mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.reg_write  = ctrl_q.reg_write;
  assign bus.vreg_write = ctrl_q.vreg_write;
  assign bus.mem_write  = ctrl_q.mem_write;
  assign bus.branch     = ctrl_q.branch;
  assign bus.alu_src    = ctrl_q.alu_src;
  assign bus.is_vec     = ctrl_q.is_vec;
  assign bus.illegal    = ctrl_q.illegal;
  assign bus.uop_idx    = idx_q;
  assign bus.lane_base  = base_q;
  assign bus.uop_last   = last_q;
endmodule

// File: tb/tb_vec_decode_stage.sv
// Directed bench for vec_decode_stage at NUM_LANES=16, LANES_PER_UOP=4.
// Beat snapshot order: {valid, alu, m2r, rw, vrw, mw, br, src, vec, ill, idx, base, last}.
module tb_vec_decode_stage;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  vec_decode_stage_if #(.NUM_LANES(16), .LANES_PER_UOP(4)) bus ();

  vec_decode_stage #(.NUM_LANES(16), .LANES_PER_UOP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] obs();
    return {bus.out_valid, bus.alu_ctrl, bus.mem_to_reg, bus.reg_write, bus.vreg_write,
            bus.mem_write, bus.branch, bus.alu_src, bus.is_vec, bus.illegal,
            bus.uop_idx, bus.lane_base, bus.uop_last};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] op, input logic rd);
    bus.opcode   = op;
    bus.rd_type  = rd;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (bus.out_valid && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: out_valid=%b after %0d cycles, required 0", bus.out_valid, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #7 rst_n = 1'b1;
    #1;
    checks++;
    if (obs() !== 19'd0) begin
      errors++; $display("FAIL reset_outputs: got %h required 0", obs());
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_scalar_add();
    send(5'b10101, 1'b0);
    checks++;
    if (obs() !== {1'b1, 2'b00, 2'b00, 7'b1000000, 2'd0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL add_beat: got %h", obs());
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL add_in_ready: got %b required 1", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL add_retire: out_valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_vector_crack();
    send(5'b10001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] k2;
      logic [3:0] b4;
      k2 = k[1:0];
      b4 = 4'(k * 4);
      checks++;
      if (obs() !== {1'b1, 2'b00, 2'b00, 7'b0100010, k2, b4, (k == 3)}) begin
        errors++; $display("FAIL vadd_beat%0d: got %h", k, obs());
      end
      checks++;
      if (bus.in_ready !== (k == 3)) begin
        errors++; $display("FAIL vadd_in_ready%0d: got %b", k, bus.in_ready);
      end
      tick();
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL vadd_retire: out_valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_sub_sbox_illegal();
    send(5'b11110, 1'b0);
    checks++;
    if (obs() !== {1'b1, 2'b01, 2'b00, 7'b1000000, 2'd0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL sub_beat: got %h", obs());
    end
    drain();
    send(5'b11110, 1'b1);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] k2;
      logic [3:0] b4;
      k2 = k[1:0];
      b4 = 4'(k * 4);
      checks++;
      if (obs() !== {1'b1, 2'b00, 2'b10, 7'b0100110, k2, b4, (k == 3)}) begin
        errors++; $display("FAIL sbox_imm_beat%0d: got %h", k, obs());
      end
      tick();
    end
    send(5'b00010, 1'b0);
    checks++;
    if (obs() !== {1'b1, 2'b00, 2'b00, 7'b0000001, 2'd0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL illegal_beat: got %h", obs());
    end
    drain();
  endtask

  task automatic test_opcode_table();
    logic [16:0] tbl [15];
    tbl[0]  = {5'b11000, 1'b0, 2'b00, 2'b00, 7'b1000100};
    tbl[1]  = {5'b01100, 1'b0, 2'b11, 2'b00, 7'b1000000};
    tbl[2]  = {5'b11011, 1'b0, 2'b00, 2'b01, 7'b1000000};
    tbl[3]  = {5'b11010, 1'b0, 2'b00, 2'b00, 7'b0010100};
    tbl[4]  = {5'b10100, 1'b0, 2'b00, 2'b00, 7'b0001000};
    tbl[5]  = {5'b11001, 1'b0, 2'b00, 2'b00, 7'b0001000};
    tbl[6]  = {5'b11111, 1'b0, 2'b10, 2'b00, 7'b1000000};
    tbl[7]  = {5'b11111, 1'b1, 2'b10, 2'b00, 7'b0100010};
    tbl[8]  = {5'b10010, 1'b0, 2'b00, 2'b00, 7'b0100110};
    tbl[9]  = {5'b00001, 1'b0, 2'b00, 2'b10, 7'b0100010};
    tbl[10] = {5'b11100, 1'b0, 2'b11, 2'b00, 7'b0100010};
    tbl[11] = {5'b10110, 1'b0, 2'b00, 2'b01, 7'b0100010};
    tbl[12] = {5'b10111, 1'b0, 2'b00, 2'b00, 7'b0010110};
    tbl[13] = {5'b00000, 1'b0, 2'b00, 2'b00, 7'b0000001};
    tbl[14] = {5'b11101, 1'b1, 2'b00, 2'b00, 7'b0000001};
    for (int i = 0; i < 15; i++) begin
      logic [10:0] ctl;
      ctl = tbl[i][10:0];
      send(tbl[i][16:12], tbl[i][11]);
      checks++;
      if (obs() !== {1'b1, ctl, 2'd0, 4'd0, ~ctl[1]}) begin
        errors++; $display("FAIL table_op%b_rd%b: got %h", tbl[i][16:12], tbl[i][11], obs());
      end
      drain();
    end
  endtask

  task automatic test_stall();
    send(5'b10001, 1'b0);
    tick();
    bus.out_ready = 1'b0;
    for (int m = 0; m < 3; m++) begin
      tick();
      checks++;
      if (obs() !== {1'b1, 2'b00, 2'b00, 7'b0100010, 2'd1, 4'd4, 1'b0} || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL stall%0d: got %h in_ready=%b", m, obs(), bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (obs() !== {1'b1, 2'b00, 2'b00, 7'b0100010, 2'd2, 4'd8, 1'b0}) begin
      errors++; $display("FAIL stall_resume: got %h", obs());
    end
    drain();
  endtask

  task automatic test_flush();
    send(5'b10001, 1'b0);
    tick();
    tick();
    checks++;
    if (bus.uop_idx !== 2'd2) begin
      errors++; $display("FAIL flush_pre_idx: got %0d required 2", bus.uop_idx);
    end
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.opcode   = 5'b10101;
    bus.rd_type  = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_in_ready: got %b required 0", bus.in_ready);
    end
    tick();
    bus.flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.uop_idx !== 2'd0) begin
      errors++; $display("FAIL flush_kill: out_valid=%b uop_idx=%0d required 0/0", bus.out_valid, bus.uop_idx);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (obs() !== {1'b1, 2'b00, 2'b00, 7'b1000000, 2'd0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL flush_reaccept: got %h", obs());
    end
    drain();
  endtask

  task automatic test_back_to_back();
    bus.opcode   = 5'b10101;
    bus.rd_type  = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    checks++;
    if (obs() !== {1'b1, 2'b00, 2'b00, 7'b1000000, 2'd0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL b2b_first: got %h", obs());
    end
    bus.opcode = 5'b10001;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_in_ready: got %b required 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (obs() !== {1'b1, 2'b00, 2'b00, 7'b0100010, 2'd0, 4'd0, 1'b0}) begin
      errors++; $display("FAIL b2b_second: got %h", obs());
    end
    drain();
  endtask

  task automatic test_async_reset();
    send(5'b10001, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 19'd0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset: got %h in_ready=%b required 0/1", obs(), bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs() !== 19'd0) begin
      errors++; $display("FAIL async_release: got %h required 0", obs());
    end
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.opcode    = 5'd0;
    bus.rd_type   = 1'b0;
    bus.rs1_type  = 1'b0;
    bus.rs2_type  = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_scalar_add();
    test_vector_crack();
    test_sub_sbox_illegal();
    test_opcode_table();
    test_stall();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
